// File: rtl/uart_tx_port.sv
// 8N1 UART transmitter fed by a 4-entry byte FIFO with a CPU-readable status word.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_port #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic [7:0] status
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t     state, state_next;
  logic [7:0] mem [4];
  logic [1:0] rd_ptr, wr_ptr;
  logic [2:0] count;
  logic       overflow;
  logic [7:0] data_reg;
  logic [7:0] baud_cnt;
  logic [2:0] bit_idx;
  logic       baud_done;
  logic       push;
  logic       pop;

  assign baud_done = (baud_cnt == 8'(CLKS_PER_BIT - 1));
  // Acceptance looks only at the registered count, so a full FIFO drops the
  // write even when the FSM frees a slot on the same edge.
  assign push      = wr_en && (count != 3'd4);
  assign fifo_full = (count == 3'd4);
  assign status    = {4'b0000, (count == 3'd0), overflow, fifo_full, busy};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != 3'd0) begin
          state_next = S_START;
          pop        = 1'b1;
        end
      end
      S_START: if (baud_done) state_next = S_DATA;
      S_DATA: begin
        if (baud_done && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_next = S_PARITY;
`else
          state_next = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (baud_done) state_next = S_STOP;
`endif
      S_STOP: begin
        if (baud_done) begin
          if (count != 3'd0) begin
            state_next = S_START;
            pop        = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    case (state)
      S_IDLE:   busy = 1'b0;
      S_START:  tx   = 1'b0;
      S_DATA:   tx   = data_reg[bit_idx];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx   = ^data_reg;
`endif
      S_STOP:   tx   = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
      data_reg <= 8'h00;
      baud_cnt <= 8'd0;
      bit_idx  <= 3'd0;
    end else begin
      if (state == S_IDLE || baud_done) baud_cnt <= 8'd0;
      else                              baud_cnt <= baud_cnt + 8'd1;
      if (state == S_DATA && baud_done) bit_idx <= bit_idx + 3'd1;
      if (pop) begin
        data_reg <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 2'd1;
      end
      if (push)          wr_ptr   <= wr_ptr + 2'd1;
      if (wr_en && !push) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; count and pointers alone decide
  // which entries are valid, and leaving it unreset keeps it plain RAM.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port: queue-based line model plus directed literal checks.
module tb_uart_tx_port;

  localparam int C = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic [7:0] status;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  uart_tx_port #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .status    (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending bytes, and the expected line level for every remaining cycle of the current frame.
  logic [7:0] m_fifo [$];
  bit         m_line [$];
  bit         m_ovf;

  function automatic void load_frame(input logic [7:0] b);
    bit bits [$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    foreach (bits[i]) for (int j = 0; j < C; j++) m_line.push_back(bits[i]);
  endfunction

  function automatic void model_step(input logic r, input logic we, input logic [7:0] d);
    int pre;
    if (r) begin
      m_fifo.delete();
      m_line.delete();
      m_ovf = 1'b0;
    end else begin
      pre = m_fifo.size();
      if (m_line.size() > 0) void'(m_line.pop_front());
      if (m_line.size() == 0 && pre > 0) load_frame(m_fifo.pop_front());
      if (we) begin
        if (pre < 4) m_fifo.push_back(d);
        else         m_ovf = 1'b1;
      end
    end
  endfunction

  initial m_ovf = 1'b0;
  always @(posedge clk) model_step(rst, wr_en, wr_data);

  always @(negedge clk) begin
    logic       e_busy;
    logic       e_tx;
    logic       e_full;
    logic [7:0] e_status;
    if (chk_en) begin
      e_busy   = (m_line.size() > 0);
      e_tx     = e_busy ? m_line[0] : 1'b1;
      e_full   = (m_fifo.size() == 4);
      e_status = {4'b0000, (m_fifo.size() == 0), m_ovf, e_full, e_busy};
      check("tx", tx, e_tx);
      check("busy", busy, e_busy);
      check("fifo_full", fifo_full, e_full);
      check("status", status, e_status);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    int          k;
    int          cnt;
    int          g;
    logic [10:0] bits;
    logic [7:0]  single;
    logic [10:0] exp_bits;

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    tick();
    tick();
    chk_en = 1;
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_status", status, 8'h08);
    rst = 1'b0;
    tick();

`ifdef UART_TX_PARITY_EN
    single   = 8'h0D;
    exp_bits = 11'h61A;
`else
    single   = 8'hF3;
    exp_bits = 11'h3E6;
`endif
    write_byte(single);
    check("latency_pre", tx, 1'b1);
    tick();
    check("latency_tx_low", tx, 1'b0);
    k    = 0;
    bits = '0;
    while (busy && k < 2000) begin
      if (k % C == C / 2 && k / C < NBITS) bits[k / C] = tx;
      k++;
      tick();
    end
    check("frame_bits", bits, exp_bits);
    check("busy_cycles", k, NBITS * C);
    check("single_status", status, 8'h08);

    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i + 1);
      tick();
      if (busy) cnt++;
    end
    wr_en = 1'b0;
    check("ovf_full", fifo_full, 1'b1);
    check("ovf_status", status, 8'h07);
    g = 0;
    while (busy && g < 3000) begin
      tick();
      if (busy) cnt++;
      g++;
    end
    check("burst_busy_cycles", cnt, 5 * NBITS * C);
    check("burst_status", status, 8'h0C);

    write_byte(8'h0D);
    write_byte(8'h0F);
    g = 0;
    while (tx !== 1'b0 && g < 100) begin
      tick();
      g++;
    end
    check("tx_fall_timeout", (g < 100), 1'b1);
    repeat (50) tick();
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hAA;
    tick();
    rst   = 1'b0;
    wr_en = 1'b0;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_status", status, 8'h08);
    cnt = 0;
    repeat (300) begin
      tick();
      if (busy || !tx) cnt++;
    end
    check("abort_no_frames", cnt, 0);

    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, 599) == 0);
      wr_en   = ($urandom_range(0, (i < 2000) ? 40 : 5) == 0);
      wr_data = 8'($urandom);
      tick();
    end
    rst   = 1'b0;
    wr_en = 1'b0;
    g     = 0;
    while (busy && g < 5000) begin
      tick();
      g++;
    end
    check("drain_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
